// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: circular fetch-to-decode buffer with flush and NOP presentation when empty
module if_fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_valid,
  input  logic [31:0]                f_pc,
  input  logic [31:0]                f_instr,
  output logic                       f_ready,
  input  logic                       pipeline_en,
  input  logic                       pipeline_flush,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instruction,
  output logic                       id_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full    = r_count == CW'(DEPTH);
  assign empty   = r_count == '0;
  assign count   = r_count;
  assign f_ready = !full;
  assign w_push  = f_valid && !full && !pipeline_flush;
  assign w_pop   = pipeline_en && !empty && !pipeline_flush;

  // head entry is shown directly; an empty buffer presents a NOP at PC 0
  always_comb begin
    id_valid       = !empty;
    id_pc          = empty ? 32'h00000000 : r_mem_pc[r_rd_ptr];
    id_instruction = empty ? NOP_INSTR : r_mem_instr[r_rd_ptr];
  end

  // pointers wrap naturally at DEPTH since DEPTH is a power of two; flush and reset clear everything
  always_ff @(posedge clk) begin
    if (rst || pipeline_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count  <= (w_push && !w_pop) ? r_count + 1'b1 :
                  (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
  end

  // entry storage needs no reset: it is only visible while the buffer is non-empty
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem_pc[r_wr_ptr]    <= f_pc;
      r_mem_instr[r_wr_ptr] <= f_instr;
    end
  end
endmodule
